// File: rtl/lfsr_uart_tx.sv
// lfsr_uart_tx: prints one LFSR word per valid/ready handshake as uppercase ASCII hex on an 8N1 UART line.
// Optional CR/LF suffix after each word is compiled in with the LFSR_TX_CRLF_EN macro.
module lfsr_uart_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DATA_W = 16
) (
  input  logic              CLK50MHZ,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              RsTx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HEX_CHARS    = DATA_W / 4;
`ifdef LFSR_TX_CRLF_EN
  localparam int NUM_CHARS    = HEX_CHARS + 2;
`else
  localparam int NUM_CHARS    = HEX_CHARS;
`endif
  localparam int IDX_W        = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] CHAR_LAST = IDX_W'(NUM_CHARS - 1);
  localparam logic [2:0]       DATA_LAST = 3'd7;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("lfsr_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if ((DATA_W < 4) || ((DATA_W % 4) != 0)) begin : g_bad_width
      $error("lfsr_uart_tx: DATA_W must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  baud_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [IDX_W-1:0]  char_idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic [7:0]        char_s;
  logic              next_bit_s;
  logic              bit_end_s;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] code;
    if (nib <= 4'd9) begin
      code = 8'h30 + {4'h0, nib};
    end else begin
      code = 8'h37 + {4'h0, nib};
    end
    return code;
  endfunction

  // Current character: the top nibble of the shift register, or CR/LF once the hex digits are spent.
  always_comb begin
    char_s = hex_ascii(shift_q[DATA_W-1 -: 4]);
`ifdef LFSR_TX_CRLF_EN
    if (char_idx_q == IDX_W'(HEX_CHARS)) begin
      char_s = 8'h0D;
    end else if (char_idx_q == IDX_W'(HEX_CHARS + 1)) begin
      char_s = 8'h0A;
    end else begin
      char_s = hex_ascii(shift_q[DATA_W-1 -: 4]);
    end
`endif
  end

  // Bit-boundary strobe and the data bit that follows the one on the line.
  always_comb begin
    bit_end_s  = (baud_cnt_q == BIT_LAST);
    next_bit_s = char_s[bit_idx_q + 3'd1];
  end

  // Frame FSM; every output is a register updated here so nothing combinational reaches a pin.
  always_ff @(posedge CLK50MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (data_valid && ready_q) begin
            shift_q    <= data_in;
            char_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
          end else begin
            baud_cnt_q <= '0;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            tx_q       <= char_s[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == DATA_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= next_bit_s;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_q <= '0;
            if (char_idx_q == CHAR_LAST) begin
              tx_q    <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Next character starts immediately; the shift exposes the next nibble.
              char_idx_q <= char_idx_q + 1'b1;
              shift_q    <= shift_q << 3'd4;
              tx_q       <= 1'b0;
              state_q    <= START;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: begin
          baud_cnt_q <= '0;
          tx_q       <= 1'b1;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign data_ready = ready_q;
  assign RsTx       = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/lfsr_uart_tx.md
# lfsr_uart_tx

Serial output stage for the LFSR pseudo-random generator, driving the board `RsTx` pin. It accepts one LFSR word per valid/ready handshake and renders it as uppercase ASCII hex, MSB nibble first. With the CR/LF option compiled in, it appends carriage return and line feed. Each character goes out as 8N1 UART at a fixed baud rate, so a terminal on the USB-UART bridge shows one random value per line.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: input clock frequency.
- `BAUD`, default 115_200: line rate.
- `DATA_W`, default 16: LFSR word width. Must be a multiple of 4 and ≥ 4.
- Derived `CLKS_PER_BIT` = (CLK_HZ + BAUD/2) / BAUD, which is 434 at defaults. Must be ≥ 2. Elaboration fails otherwise.

Ports:
- `CLK50MHZ`  in  1  system clock; all logic on the rising edge. This is the block's one clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `data_in`  in  DATA_W  LFSR word; sampled only on the handshake edge.
- `data_valid`  in  1  upstream word available.
- `data_ready`  out  1  block can accept a word (idle).
- `RsTx`  out  1  UART serial output; idle high.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse when the last stop bit of a frame completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `data_ready`=1, `busy`=0, `RsTx`=1.
  - On `data_valid & data_ready`, capture `data_in` into a shift register and go to START with char index 0.
- Character generation:
  - Char i (i < DATA_W/4) is nibble n = bits [DATA_W-1-4i -: 4].
  - ASCII = 0x30+n for n ≤ 9, and 0x37+n for n ≥ 10 (uppercase A–F).
  - With CR/LF enabled, the next two chars are 0x0D and 0x0A.
- START: `RsTx`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
- STOP: `RsTx`=1 for CLKS_PER_BIT cycles.
  - If more chars remain, go straight to START for the next char, with no extra idle cycles.
  - Otherwise go to IDLE.
- Words offered while `busy`=1 are not accepted and are not queued. Upstream holds or drops them.
- `data_in` changes during a frame have no effect.
- Baud counter width is $clog2(CLKS_PER_BIT). It reloads at every bit boundary, so there is no cumulative drift.

## Timing
- Reset values:
  - `RsTx`=1, `data_ready`=1, `busy`=0, `frame_done`=0.
  - FSM in IDLE; counters and shift register cleared.
- Assertion of `reset_n` acts immediately, asynchronously, including mid-frame:
  - the partial character is abandoned;
  - `RsTx` goes high at once;
  - `frame_done` is not pulsed.
- Handshake at edge k:
  - `data_ready`=0, `busy`=1 and `RsTx`=0 (start bit) all take effect from edge k+1.
- Frame length, measured from the first start-bit cycle: chars × 10 × CLKS_PER_BIT cycles.
  - Default build: 6 chars = 26_040 cycles.
  - Without CR/LF: 4 chars = 17_360 cycles.
- At the edge that ends the final stop bit:
  - FSM enters IDLE;
  - `frame_done`=1 for exactly one cycle;
  - `data_ready`=1 and `busy`=0 in that same cycle.
- Back-to-back operation: if `data_valid` is high during the `frame_done` cycle, the next word is captured on that edge. Exactly one idle-high cycle then separates the previous stop bit from the next start bit.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `LFSR_TX_CRLF_EN`:
  - Defined (board default): each frame is DATA_W/4 hex chars followed by 0x0D, 0x0A.
  - Undefined: frame is the DATA_W/4 hex chars only. The CR/LF character logic is compiled out and the char-index counter terminates at DATA_W/4-1.

## Test plan
Bench parameters: CLK_HZ=50_000_000, BAUD=12_500_000 (CLKS_PER_BIT=4), unless a case states otherwise. The bench's UART model samples mid-bit.

- Basic frame: `LFSR_TX_CRLF_EN` defined, `data_in`=16'hA5C3 with valid for one cycle. Required: bytes 0x41, 0x35, 0x43, 0x33, 0x0D, 0x0A decoded; `frame_done` pulse 240 cycles after the start-bit cycle.
- CR/LF compiled out, same stimulus. Required: only 0x41, 0x35, 0x43, 0x33; `frame_done` after 160 cycles.
- Back-to-back: `data_valid` held high across 16'h0000 then 16'hFFFF. Required: "0000\r\n" then "FFFF\r\n"; exactly one idle-high cycle between frames.
- Valid while busy: 16'h1234 pulsed mid-frame. Required: not transmitted; `data_ready` stays 0 until `frame_done`.
- Reset mid-frame: `reset_n` low during a data bit of char 2. Required: `RsTx`=1, `busy`=0, `data_ready`=1 immediately; no `frame_done`. After release, 16'h00FF transmits cleanly as "00FF\r\n".
- Default parameters: every bit measures exactly 434 cycles; idle line stays high.
